seq_mult_nxn: RTL and testbench
===============================

Name: seq_mult_nxn

Overview:
- Parametrised sequential WIDTH x WIDTH multiplier, the successor to the team's single-cycle 4x4 unsigned multiply.
- Contains exactly one 4x4 unsigned multiply datapath. It iterates over nibble pairs and shift-accumulates the partial products.
- Adds a signed/unsigned mode and valid/ready handshakes on input and output.
- Sits between an operand producer and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NIB, WIDTH/4 (derived, not overridable), nibbles per operand.
- NPP, NIB*NIB (derived), number of partial products, equal to the number of CALC cycles.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands and mode are presented
- in_ready  output  1  block can accept operands
- dataa  input  WIDTH  multiplicand
- datab  input  WIDTH  multiplier
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned
- out_valid  output  1  product is valid
- out_ready  input  1  consumer accepts the product
- product  output  2*WIDTH  result register
- busy  output  1  high in CALC or FINAL

Behaviour:
- Only one clock and one reset; reset is synchronous and active-high. Every register, including the FSM, is sampled on rising clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator=0, nibble counters=0.

States:
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready the block captures the operands.
  - In signed mode it stores the magnitudes |dataa| and |datab| and stores neg = sign(a) XOR sign(b). In unsigned mode it stores the operands raw and sets neg=0.
  - It clears the accumulator and goes to CALC.
- CALC:
  - Lasts NPP cycles, with i (nibble of a) as the inner loop and j (nibble of b) as the outer loop.
  - Each cycle: acc += (a_nib[i] * b_nib[j]) << 4*(i+j). The multiply is 4x4 -> 8 bits unsigned. The accumulator is 2*WIDTH bits and cannot overflow.
  - After pair (NIB-1, NIB-1) it goes to FINAL.
- FINAL:
  - product <= neg ? -acc : acc, taken modulo 2^(2*WIDTH).
  - out_valid <= 1, then go to DONE.
- DONE:
  - out_valid=1 and product held stable.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE.
  - product keeps its last value until the next FINAL.

Handshake and latency:
- Latency: if accept happens at edge k, out_valid is high after edge k+NPP+1. For WIDTH=8 that is 5 edges.
- in_ready=0 in CALC, FINAL and DONE. in_valid during those states is ignored, and operands are not re-sampled.
- Throughput is one product per NPP+3 cycles minimum. There is no accept in the same cycle as the output handshake; IDLE is always visited.

Boundary and arithmetic rules:
- Signed magnitude of the most-negative value (e.g. -128 for WIDTH=8) is 2^(WIDTH-1). It is held in WIDTH unsigned bits, so no overflow: -128*-128 = 16384.
- A zero operand still takes the full NPP cycles. A zero result with neg=1 yields 0, never a negative zero artefact.
- signed_mode is sampled only at accept. Changing it later has no effect.
- Reset asserted in any state, including mid-CALC or in DONE, aborts the operation. It applies the reset values at that edge, so in_ready=1 on the following cycle.
- out_ready while out_valid=0 is ignored.

Test Plan:
- WIDTH=8, unsigned, a=5, b=3, out_ready=1 -> product=0x000F; out_valid rises exactly 5 edges after accept; in_ready low for that span.
- Unsigned a=0xFF, b=0xFF -> 0xFE01. Then signed a=0xFF (-1), b=0x01 -> 0xFFFF. Then unsigned a=0xFF, b=0x01 -> 0x00FF.
- Signed a=0x80, b=0x80 -> 0x4000. Signed a=0xFD (-3), b=0x07 -> 0xFFEB (-21). Signed a=0x00, b=0x80 -> 0x0000.
- Backpressure: after out_valid, hold out_ready=0 for 10 cycles while toggling in_valid and operands -> product stable, out_valid held, in_ready=0. Raise out_ready -> in_ready=1 next cycle, and a new op is accepted correctly.
- Assert reset for 1 cycle during the 2nd CALC cycle -> next cycle in_ready=1, out_valid=0, product=0. A following 6*4 op returns 0x0018.
- WIDTH=16 instance: unsigned 0xFFFF*0xFFFF -> 0xFFFE0001 after 17 edges; signed 0x8000*0x7FFF -> 0xC0008000.

Source files
------------

// File: rtl/seq_mult_nxn.sv
// Sequential WIDTH x WIDTH multiplier built around a single 4x4 unsigned
// multiply; nibble partial products are shift-accumulated over NIB*NIB cycles.
module seq_mult_nxn #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     dataa,
   input  logic [WIDTH-1:0]     datab,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int PW  = 2 * WIDTH;

   generate
      if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
         $error("seq_mult_nxn: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CALC, FINAL, DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              neg_q, neg_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     product_q, product_d;
   logic [CW-1:0]     i_q, i_d;
   logic [CW-1:0]     j_q, j_d;
   logic              out_valid_q, out_valid_d;

   logic [WIDTH-1:0]  a_mag, b_mag;
   logic [3:0]        a_nib, b_nib;
   logic [7:0]        pp;
   logic [PW-1:0]     pp_ext;
   logic              last_i, last_j;

   // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is
   // exactly right when the result is read as unsigned WIDTH bits.
   assign a_mag = (signed_mode && dataa[WIDTH-1]) ? -dataa : dataa;
   assign b_mag = (signed_mode && datab[WIDTH-1]) ? -datab : datab;

   assign a_nib  = a_q[4*int'(i_q) +: 4];
   assign b_nib  = b_q[4*int'(j_q) +: 4];
   assign pp     = {4'b0000, a_nib} * {4'b0000, b_nib};
   assign pp_ext = PW'(pp) << (4 * (int'(i_q) + int'(j_q)));

   assign last_i = (i_q == CW'(NIB - 1));
   assign last_j = (j_q == CW'(NIB - 1));

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      neg_d       = neg_q;
      acc_d       = acc_q;
      i_d         = i_q;
      j_d         = j_q;
      product_d   = product_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a_mag;
               b_d     = b_mag;
               neg_d   = signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = acc_q + pp_ext;
            // i walks the nibbles of a inside each nibble of b
            if (last_i) begin
               i_d = '0;
               if (last_j) begin
                  j_d     = '0;
                  state_d = FINAL;
               end else begin
                  j_d = j_q + CW'(1);
               end
            end else begin
               i_d = i_q + CW'(1);
            end
         end
         FINAL: begin
            product_d   = neg_q ? -acc_q : acc_q;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         neg_q       <= 1'b0;
         acc_q       <= '0;
         product_q   <= '0;
         i_q         <= '0;
         j_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         neg_q       <= neg_d;
         acc_q       <= acc_d;
         product_q   <= product_d;
         i_q         <= i_d;
         j_q         <= j_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == CALC) || (state_q == FINAL);
   assign out_valid = out_valid_q;
   assign product   = product_q;

endmodule

// File: tb/tb_seq_mult_nxn.sv
// Scoreboard bench for seq_mult_nxn: WIDTH=8 and WIDTH=16 instances share clk/reset.
module tb_seq_mult_nxn;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
   logic [7:0]  dataa, datab;
   logic [15:0] product;
   logic        in_valid16, in_ready16, signed_mode16, out_valid16, out_ready16, busy16;
   logic [15:0] dataa16, datab16;
   logic [31:0] product16;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp8_q[$];
   logic [31:0] exp16_q[$];

   always #5 clk = ~clk;

   seq_mult_nxn #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .dataa(dataa), .datab(datab), .signed_mode(signed_mode),
      .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
   );

   seq_mult_nxn #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
      .dataa(dataa16), .datab(datab16), .signed_mode(signed_mode16),
      .out_valid(out_valid16), .out_ready(out_ready16), .product(product16), .busy(busy16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference product: sign-extend when signed, multiply, keep 2*w bits.
   function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic sm, input int w);
      longint sa, sb, r;
      sa = longint'(a);
      sb = longint'(b);
      if (sm) begin
         if (a[w-1]) sa = sa - (longint'(1) << w);
         if (b[w-1]) sb = sb - (longint'(1) << w);
      end
      r = sa * sb;
      return 32'(r & ((longint'(1) << (2 * w)) - 1));
   endfunction

   // Drives one op into dut8, pushes expv at accept, waits for the result,
   // holds out_ready low for 'hold' cycles, then completes the handshake.
   task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         input int hold, input logic [31:0] expv,
                         output int lat, output logic [15:0] got,
                         output logic leak, output logic bbad);
      int n;
      dataa = a; datab = b; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 100) begin tick(); n++; end
      tick();
      in_valid = 1'b0; dataa = ~a; datab = ~b; signed_mode = ~sm;
      exp8_q.push_back(expv);
      lat = 0; leak = 1'b0; bbad = !busy;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
         if (in_ready) leak = 1'b1;
         if ((lat < 5 && !busy) || (lat >= 5 && busy)) bbad = 1'b1;
      end
      repeat (hold) tick();
      got = product;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got %h exp 0000", product); end
      checks++; if (in_ready16 !== 1'b1 || product16 !== 32'h0) begin errors++; $display("FAIL reset_w16 got rdy %b prod %h exp 1 0", in_ready16, product16); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int lat; logic [15:0] got; logic leak, bbad; logic [31:0] e;
      do_op8(8'h05, 8'h03, 1'b0, 0, 32'h000F, lat, got, leak, bbad);
      e = exp8_q.pop_front();
      checks++; if (got !== e[15:0]) begin errors++; $display("FAIL basic_product got %h exp %h", got, e[15:0]); end
      checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency got %0d exp 5", lat); end
      checks++; if (leak !== 1'b0) begin errors++; $display("FAIL basic_in_ready_low got leak %b exp 0", leak); end
      checks++; if (bbad !== 1'b0) begin errors++; $display("FAIL basic_busy got bad %b exp 0", bbad); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b exp 1", in_ready); end
   endtask

   task automatic test_arith();
      logic [7:0]  ta[6];
      logic [7:0]  tb[6];
      logic        ts[6];
      logic [15:0] te[6];
      int lat; logic [15:0] got; logic leak, bbad; logic [31:0] e;
      ta = '{8'hFF, 8'hFF, 8'hFF, 8'h80, 8'hFD, 8'h00};
      tb = '{8'hFF, 8'h01, 8'h01, 8'h80, 8'h07, 8'h80};
      ts = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
      te = '{16'hFE01, 16'hFFFF, 16'h00FF, 16'h4000, 16'hFFEB, 16'h0000};
      for (int k = 0; k < 6; k++) begin
         do_op8(ta[k], tb[k], ts[k], k % 3, {16'h0, te[k]}, lat, got, leak, bbad);
         e = exp8_q.pop_front();
         checks++; if (got !== e[15:0]) begin errors++; $display("FAIL arith_%0d got %h exp %h", k, got, e[15:0]); end
         checks++; if (lat != 5) begin errors++; $display("FAIL arith_lat_%0d got %0d exp 5", k, lat); end
      end
   endtask

   task automatic test_backpressure();
      int n, lat; logic [15:0] got; logic leak, bbad; logic [31:0] e;
      dataa = 8'h0C; datab = 8'h0B; signed_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 100) begin tick(); n++; end
      tick();
      exp8_q.push_back(32'h0084);
      lat = 0;
      while (!out_valid && lat < 200) begin tick(); lat++; end
      e = exp8_q[0];
      for (int c = 0; c < 10; c++) begin
         in_valid = ~in_valid; dataa = 8'($urandom); datab = 8'($urandom); signed_mode = ~signed_mode;
         tick();
         checks++; if (product !== e[15:0]) begin errors++; $display("FAIL bp_product_%0d got %h exp %h", c, product, e[15:0]); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_%0d got %b exp 1", c, out_valid); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d got %b exp 0", c, in_ready); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      void'(exp8_q.pop_front());
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", out_valid); end
      do_op8(8'hA5, 8'h3C, 1'b0, 0, 32'h26AC, lat, got, leak, bbad);
      e = exp8_q.pop_front();
      checks++; if (got !== e[15:0]) begin errors++; $display("FAIL bp_next_op got %h exp %h", got, e[15:0]); end
   endtask

   task automatic test_reset_mid_calc();
      int n, lat; logic [15:0] got; logic leak, bbad; logic [31:0] e;
      dataa = 8'h09; datab = 8'h07; signed_mode = 1'b0; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin tick(); n++; end
      tick();
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b exp 0", out_valid); end
      checks++; if (product !== 16'h0000) begin errors++; $display("FAIL abort_product got %h exp 0000", product); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
      do_op8(8'h06, 8'h04, 1'b0, 1, 32'h0018, lat, got, leak, bbad);
      e = exp8_q.pop_front();
      checks++; if (got !== e[15:0]) begin errors++; $display("FAIL abort_next_op got %h exp %h", got, e[15:0]); end
      checks++; if (lat != 5) begin errors++; $display("FAIL abort_next_lat got %0d exp 5", lat); end
   endtask

   task automatic test_random8();
      int lat; logic [15:0] got; logic leak, bbad; logic [31:0] e;
      logic [7:0] a, b; logic sm;
      for (int k = 0; k < 16; k++) begin
         a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom_range(0, 1));
         do_op8(a, b, sm, $urandom_range(0, 3), model({8'h0, a}, {8'h0, b}, sm, 8), lat, got, leak, bbad);
         e = exp8_q.pop_front();
         checks++; if (got !== e[15:0]) begin errors++; $display("FAIL rand8_%0d a %h b %h s %b got %h exp %h", k, a, b, sm, got, e[15:0]); end
      end
   endtask

   task automatic test_width16();
      logic [15:0] ta[6];
      logic [15:0] tb[6];
      logic        ts[6];
      logic [31:0] e, expv;
      int n, lat;
      ta = '{16'hFFFF, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0};
      tb = '{16'hFFFF, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0};
      ts = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int k = 2; k < 6; k++) begin
         ta[k] = 16'($urandom); tb[k] = 16'($urandom); ts[k] = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < 6; k++) begin
         if (k == 0) expv = 32'hFFFE0001;
         else if (k == 1) expv = 32'hC0008000;
         else expv = model(ta[k], tb[k], ts[k], 16);
         dataa16 = ta[k]; datab16 = tb[k]; signed_mode16 = ts[k]; in_valid16 = 1'b1;
         n = 0;
         while (!in_ready16 && n < 100) begin tick(); n++; end
         tick();
         in_valid16 = 1'b0;
         exp16_q.push_back(expv);
         lat = 0;
         while (!out_valid16 && lat < 200) begin tick(); lat++; end
         e = exp16_q.pop_front();
         checks++; if (product16 !== e) begin errors++; $display("FAIL w16_%0d got %h exp %h", k, product16, e); end
         checks++; if (lat != 17) begin errors++; $display("FAIL w16_lat_%0d got %0d exp 17", k, lat); end
         out_ready16 = 1'b1;
         tick();
         out_ready16 = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; dataa = 8'h0; datab = 8'h0; signed_mode = 1'b0; out_ready = 1'b0;
      in_valid16 = 1'b0; dataa16 = 16'h0; datab16 = 16'h0; signed_mode16 = 1'b0; out_ready16 = 1'b0;
      test_reset();
      test_basic();
      test_arith();
      test_backpressure();
      test_reset_mid_calc();
      test_random8();
      test_width16();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
